store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of buffered store entries (power of 2, 2..8).
REQ-002 clk  input  1  rising-edge clock shared with data memory.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_mem_write  input  1  store request from the CPU this cycle.
REQ-005 cpu_mem_read  input  1  load request from the CPU this cycle.
REQ-006 cpu_address  input  16  load/store byte-independent word address.
REQ-007 cpu_write_data  input  16  store data.
REQ-008 cpu_read_data  output  16  load result, combinational.
REQ-009 stall  output  1  CPU must hold its request and retry next cycle.
REQ-010 mem_write  output  1  write strobe to data memory.
REQ-011 mem_address  output  16  address to data memory.
REQ-012 mem_write_data  output  16  write data to data memory.
REQ-013 mem_read_data  input  16  combinational read data from data memory.
REQ-014 empty  output  1  high when no entries are buffered.
REQ-015 count  output  4  number of valid entries, 0..DEPTH.

Function
REQ-016 The block SHALL hold a circular FIFO of DEPTH {address, data} entries with head/tail pointers wrapping modulo DEPTH.
REQ-017 full SHALL be count==DEPTH; empty SHALL be count==0.
REQ-018 stall SHALL be combinational: full && (cpu_mem_write || cpu_mem_read); otherwise 0.
REQ-019 A store with stall==0 SHALL be enqueued at the tail on the next rising edge; a stalled store SHALL be dropped by the block (CPU retries).
REQ-020 Drain condition: count>0 && (cpu_mem_read==0 || full).
REQ-021 When draining: mem_write=1, mem_address=head address, mem_write_data=head data; head SHALL advance on the same rising edge (one entry per cycle).
REQ-022 When not draining: mem_write=0, mem_address=cpu_address, mem_write_data=0.
REQ-023 Unstalled load: cpu_read_data SHALL equal data of the youngest valid entry whose address[7:0] equals cpu_address[7:0]; if no match, mem_read_data.
REQ-024 Forwarding SHALL compare only address[7:0], matching the 256-word memory aliasing.
REQ-025 Load and store in the same unstalled cycle: load SHALL see entries present before this cycle's store; store enqueues at the edge.
REQ-026 Simultaneous enqueue and drain: count SHALL be unchanged, both pointers advance.
REQ-027 Duplicate addresses in the FIFO SHALL be preserved and drained in program order (no merging).
REQ-028 During stall, cpu_read_data is don't-care; memory contents SHALL only change via drains.
REQ-029 count SHALL never exceed DEPTH nor go below 0 under any input sequence.

Reset
REQ-030 On rst high, asynchronously: head=0, tail=0, count=0, all entry valid state cleared.
REQ-031 While rst high: empty=1, count=0, stall=0, mem_write=0, mem_address=cpu_address.
REQ-032 Reset mid-operation SHALL discard all buffered stores without writing them to memory.
REQ-033 First enqueue SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-034 Store 0x1234 to addr 0x0005, no loads -> next cycle mem_write=1, mem_address=0x0005, mem_write_data=0x1234; following cycle empty=1.
REQ-035 Store 0xAAAA then 0xBBBB to addr 0x0010, load 0x0010 while both buffered (loads held high) -> cpu_read_data=0xBBBB, mem_write=0; after loads stop, memory written 0xAAAA then 0xBBBB.
REQ-036 Load addr 0x0110 with buffered entry at 0x0010 data 0x5555 -> cpu_read_data=0x5555 (8-bit compare).
REQ-037 Four stores with cpu_mem_read held high -> count=4, then fifth store -> stall=1, mem_write=1 draining head; next cycle stall=0, store accepted, count=4.
REQ-038 Three entries buffered, pulse rst -> count=0, empty=1, mem_write=0, no memory writes of discarded data; load of those addresses returns memory's prior value.
REQ-039 Load 0x0001 with empty buffer -> cpu_read_data=mem_read_data (0x2022 with memory preloaded), mem_address=0x0001.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between CPU and data memory.
// Holds DEPTH buffered stores in a circular FIFO. Buffered entries drain to
// memory one per cycle whenever the CPU is not loading, or unconditionally
// once the buffer is full. Loads forward the youngest matching buffered store.
// Address matching uses only bits [7:0] because the data memory holds
// 256 words and aliases every higher address onto them.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_mem_write,
  input  logic        cpu_mem_read,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_write_data,
  output logic [15:0] cpu_read_data,
  output logic        stall,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_read_data,
  output logic        empty,
  output logic [3:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]      addr_q [DEPTH];
  logic [15:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [3:0]       count_q, count_d;

  logic             full;
  logic             enq;
  logic             drain;
  logic [PW-1:0]    fwd_idx;
  logic [15:0]      fwd_data;

  assign full  = (count_q == 4'(DEPTH));
  assign empty = (count_q == 4'd0);
  assign count = count_q;
  assign stall = full && (cpu_mem_write || cpu_mem_read);

  // A stalled store is dropped here; the CPU retries it next cycle.
  assign enq   = cpu_mem_write && !stall;
  // A pending load gets the memory port unless the buffer must make room.
  assign drain = !empty && (!cpu_mem_read || full);

  // Memory port: drain the head entry, otherwise pass the CPU address through
  // so loads that miss in the buffer read memory directly.
  always_comb begin
    mem_write      = 1'b0;
    mem_address    = cpu_address;
    mem_write_data = 16'h0000;
    if (drain) begin
      mem_write      = 1'b1;
      mem_address    = addr_q[head_q];
      mem_write_data = data_q[head_q];
    end
  end

  // Forwarding: walk oldest to youngest so the last hit (youngest) wins.
  // Only registered entries are visited, so a store arriving this cycle is
  // not visible to a load in the same cycle.
  always_comb begin
    fwd_data = mem_read_data;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((4'(i) < count_q) && valid_q[fwd_idx] &&
          (addr_q[fwd_idx][7:0] == cpu_address[7:0])) begin
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign cpu_read_data = fwd_data;

  // Pointer and occupancy next-state; enqueue and drain together leave the
  // count unchanged. Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      tail_d = tail_q + PW'(1);
    end
    if (drain) begin
      head_d = head_q + PW'(1);
    end
    count_d = count_q + {3'b000, enq} - {3'b000, drain};
  end

  // Pointer/occupancy registers; reset discards every buffered store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 4'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry valid bits: set on enqueue at the tail, cleared on drain at the head.
  // The two never collide: draining needs an entry, enqueueing needs a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
      end
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
      end
    end
  end

  // Entry payload storage; contents are qualified by valid_q so no reset needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= cpu_address;
      data_q[tail_q] <= cpu_write_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a 256-word aliased memory model.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        cpu_mem_write;
  logic        cpu_mem_read;
  logic [15:0] cpu_address;
  logic [15:0] cpu_write_data;
  logic [15:0] cpu_read_data;
  logic        stall;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        empty;
  logic [3:0]  count;

  int checks;
  int failures;

  logic [15:0] mem [256];
  logic [15:0] wl_addr [$];
  logic [15:0] wl_data [$];

  store_buffer #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_mem_write  (cpu_mem_write),
    .cpu_mem_read   (cpu_mem_read),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .stall          (stall),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .empty          (empty),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:0]];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address[7:0]] <= mem_write_data;
      wl_addr.push_back(mem_address);
      wl_data.push_back(mem_write_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (empty === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_mem_write = 1'b1;
    cpu_mem_read = 1'b1;
    cpu_address = 16'h00AB;
    cpu_write_data = 16'h9999;
    #2;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    checks++; if (mem_address !== 16'h00AB) begin failures++; $display("FAIL reset_mem_address got=%h exp=00ab", mem_address); end
    tick();
    tick();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_held_count got=%0d exp=0", count); end
    cpu_mem_write = 1'b0;
    cpu_mem_read = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_empty_load();
    cpu_mem_read = 1'b1;
    cpu_address = 16'h0001;
    #1;
    checks++; if (cpu_read_data !== 16'h2022) begin failures++; $display("FAIL empty_load_data got=%h exp=2022", cpu_read_data); end
    checks++; if (mem_address !== 16'h0001) begin failures++; $display("FAIL empty_load_addr got=%h exp=0001", mem_address); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL empty_load_wr got=%b exp=0", mem_write); end
    cpu_mem_read = 1'b0;
    tick();
  endtask

  task automatic test_single_store();
    bit ok;
    wl_addr.delete(); wl_data.delete();
    cpu_mem_write = 1'b1;
    cpu_address = 16'h0005;
    cpu_write_data = 16'h1234;
    #1;
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL single_pre_wr got=%b exp=0", mem_write); end
    tick();
    cpu_mem_write = 1'b0;
    cpu_address = 16'h0077;
    #1;
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL single_wr got=%b exp=1", mem_write); end
    checks++; if (mem_address !== 16'h0005) begin failures++; $display("FAIL single_addr got=%h exp=0005", mem_address); end
    checks++; if (mem_write_data !== 16'h1234) begin failures++; $display("FAIL single_data got=%h exp=1234", mem_write_data); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b exp=1", empty); end
    checks++; if (mem_write_data !== 16'h0000) begin failures++; $display("FAIL single_idle_wdata got=%h exp=0000", mem_write_data); end
    checks++; if (mem[5] !== 16'h1234) begin failures++; $display("FAIL single_mem got=%h exp=1234", mem[5]); end
    wait_empty(ok);
    checks++; if (wl_addr.size() != 1) begin failures++; $display("FAIL single_nwrites got=%0d exp=1", wl_addr.size()); end
  endtask

  task automatic test_forward_order();
    bit ok;
    wl_addr.delete(); wl_data.delete();
    cpu_mem_read = 1'b1;
    cpu_mem_write = 1'b1;
    cpu_address = 16'h0010;
    cpu_write_data = 16'hAAAA;
    #1;
    checks++; if (cpu_read_data !== 16'hC010) begin failures++; $display("FAIL same_cycle_load0 got=%h exp=c010", cpu_read_data); end
    tick();
    cpu_write_data = 16'hBBBB;
    #1;
    checks++; if (cpu_read_data !== 16'hAAAA) begin failures++; $display("FAIL same_cycle_load1 got=%h exp=aaaa", cpu_read_data); end
    tick();
    cpu_mem_write = 1'b0;
    #1;
    checks++; if (cpu_read_data !== 16'hBBBB) begin failures++; $display("FAIL fwd_youngest got=%h exp=bbbb", cpu_read_data); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL fwd_no_drain got=%b exp=0", mem_write); end
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL fwd_count got=%0d exp=2", count); end
    cpu_mem_read = 1'b0;
    #1;
    checks++; if (mem_write_data !== 16'hAAAA) begin failures++; $display("FAIL drain_first got=%h exp=aaaa", mem_write_data); end
    tick();
    checks++; if (mem_write_data !== 16'hBBBB) begin failures++; $display("FAIL drain_second got=%h exp=bbbb", mem_write_data); end
    wait_empty(ok);
    checks++; if (!ok) begin failures++; $display("FAIL fwd_drain_timeout got=notempty exp=empty"); end
    checks++; if (wl_data.size() != 2 || wl_data[0] !== 16'hAAAA || wl_data[1] !== 16'hBBBB) begin
      failures++; $display("FAIL fwd_write_order got_n=%0d exp=aaaa,bbbb", wl_data.size());
    end
    checks++; if (mem[8'h10] !== 16'hBBBB) begin failures++; $display("FAIL fwd_mem_final got=%h exp=bbbb", mem[8'h10]); end
  endtask

  task automatic test_alias();
    bit ok;
    cpu_mem_read = 1'b1;
    cpu_mem_write = 1'b1;
    cpu_address = 16'h0010;
    cpu_write_data = 16'h5555;
    tick();
    cpu_mem_write = 1'b0;
    cpu_address = 16'h0110;
    #1;
    checks++; if (cpu_read_data !== 16'h5555) begin failures++; $display("FAIL alias_hit got=%h exp=5555", cpu_read_data); end
    cpu_address = 16'h0011;
    #1;
    checks++; if (cpu_read_data !== 16'hC011) begin failures++; $display("FAIL alias_miss got=%h exp=c011", cpu_read_data); end
    cpu_mem_read = 1'b0;
    wait_empty(ok);
    checks++; if (!ok) begin failures++; $display("FAIL alias_drain_timeout got=notempty exp=empty"); end
  endtask

  task automatic test_full_stall();
    bit ok;
    wl_addr.delete(); wl_data.delete();
    cpu_mem_read = 1'b1;
    cpu_mem_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_address = 16'h0020 + 16'(i);
      cpu_write_data = 16'h1000 + 16'(i);
      tick();
    end
    cpu_address = 16'h0024;
    cpu_write_data = 16'h1004;
    #1;
    checks++; if (count !== 4'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_stall got=%b exp=1", stall); end
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL full_drain got=%b exp=1", mem_write); end
    checks++; if (mem_address !== 16'h0020) begin failures++; $display("FAIL full_drain_addr got=%h exp=0020", mem_address); end
    checks++; if (mem_write_data !== 16'h1000) begin failures++; $display("FAIL full_drain_data got=%h exp=1000", mem_write_data); end
    tick();
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL full_after_drop got=%0d exp=3", count); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL full_unstall got=%b exp=0", stall); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL full_load_priority got=%b exp=0", mem_write); end
    tick();
    checks++; if (count !== 4'd4) begin failures++; $display("FAIL full_retry_count got=%0d exp=4", count); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_restall got=%b exp=1", stall); end
    cpu_mem_read = 1'b0;
    cpu_mem_write = 1'b0;
    wait_empty(ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_drain_timeout got=notempty exp=empty"); end
    checks++; if (wl_addr.size() != 5) begin failures++; $display("FAIL full_nwrites got=%0d exp=5", wl_addr.size()); end
    for (int i = 0; i < 5 && i < wl_addr.size(); i++) begin
      checks++;
      if (wl_addr[i] !== 16'h0020 + 16'(i) || wl_data[i] !== 16'h1000 + 16'(i)) begin
        failures++; $display("FAIL full_order[%0d] got=%h/%h exp=%h/%h", i, wl_addr[i], wl_data[i], 16'h0020 + 16'(i), 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wl_addr.delete(); wl_data.delete();
    cpu_mem_read = 1'b0;
    cpu_mem_write = 1'b1;
    cpu_address = 16'h0050;
    cpu_write_data = 16'h5050;
    tick();
    cpu_address = 16'h0051;
    cpu_write_data = 16'h5151;
    #1;
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL b2b_count0 got=%0d exp=1", count); end
    checks++; if (mem_address !== 16'h0050) begin failures++; $display("FAIL b2b_addr0 got=%h exp=0050", mem_address); end
    tick();
    cpu_mem_write = 1'b0;
    #1;
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL b2b_count1 got=%0d exp=1", count); end
    checks++; if (mem_write_data !== 16'h5151) begin failures++; $display("FAIL b2b_data1 got=%h exp=5151", mem_write_data); end
    wait_empty(ok);
    checks++; if (!ok || wl_addr.size() != 2) begin failures++; $display("FAIL b2b_nwrites got=%0d exp=2", wl_addr.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    cpu_mem_read = 1'b1;
    cpu_mem_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_address = 16'h0030 + 16'(i);
      cpu_write_data = 16'hDEA0 + 16'(i);
      tick();
    end
    cpu_mem_write = 1'b0;
    cpu_address = 16'h0030;
    #1;
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL rmid_pre_count got=%0d exp=3", count); end
    wl_addr.delete(); wl_data.delete();
    rst = 1'b1;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rmid_empty got=%b exp=1", empty); end
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rmid_wr got=%b exp=0", mem_write); end
    checks++; if (cpu_read_data !== 16'hC030) begin failures++; $display("FAIL rmid_load got=%h exp=c030", cpu_read_data); end
    tick();
    rst = 1'b0;
    cpu_mem_read = 1'b0;
    cpu_mem_write = 1'b1;
    cpu_address = 16'h0040;
    cpu_write_data = 16'h4444;
    tick();
    cpu_mem_write = 1'b0;
    cpu_mem_read = 1'b1;
    cpu_address = 16'h0031;
    #1;
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL first_enq_count got=%0d exp=1", count); end
    checks++; if (cpu_read_data !== 16'hC031) begin failures++; $display("FAIL rmid_load2 got=%h exp=c031", cpu_read_data); end
    cpu_mem_read = 1'b0;
    wait_empty(ok);
    tick();
    checks++; if (wl_addr.size() != 1 || wl_addr[0] !== 16'h0040 || wl_data[0] !== 16'h4444) begin
      failures++; $display("FAIL rmid_writes got_n=%0d exp=1 write 0040/4444", wl_addr.size());
    end
    checks++; if (mem[8'h32] !== 16'hC032) begin failures++; $display("FAIL rmid_mem got=%h exp=c032", mem[8'h32]); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
    mem[1] = 16'h2022;
    test_reset();
    test_empty_load();
    test_single_store();
    test_forward_order();
    test_alias();
    test_full_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
